// File: rtl/hex_display_pkg.sv
// Shared types and constants for the HEX display scheduler.
package hex_display_pkg;

    typedef enum logic [1:0] {
        SRC_SW    = 2'd0,
        SRC_GAME  = 2'd1,
        SRC_EVENT = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        SHOW_SW    = 2'd0,
        SHOW_GAME  = 2'd1,
        SHOW_EVENT = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic src_e state_to_src(input state_e s);
        src_e r;
        case (s)
            SHOW_GAME:  r = SRC_GAME;
            SHOW_EVENT: r = SRC_EVENT;
            default:    r = SRC_SW;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Hex nibble to active-low 7-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex_to_sevenseg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_sched.sv
// Arbitrates the 4-digit HEX display between the software word, the game score
// and preempting hardware events; pins are registered one cycle after state.
//
// state      | meaning
// SHOW_SW    | software PIO word shown, dwell timer runs while rotate_en
// SHOW_GAME  | {score_l, score_r} shown, dwell timer runs while rotate_en
// SHOW_EVENT | latched event word shown blinking until the event timer expires
module hex_display_sched
    import hex_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int EVENT_CYCLES = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sw_value,
    input  logic [7:0]  score_l,
    input  logic [7:0]  score_r,
    input  logic        rotate_en,
    input  logic        evt_req,
    input  logic [15:0] evt_data,
    output logic        evt_ack,
    output logic        evt_done,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [1:0]  src
);

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int EW = $clog2(EVENT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [EW-1:0] EVENT_LAST = EW'(EVENT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    state_e          state, state_nxt;
    logic [DW-1:0]   dwell_cnt, dwell_nxt;
    logic [EW-1:0]   evt_cnt, evt_cnt_nxt;
    logic [BW-1:0]   blink_cnt, blink_cnt_nxt;
    logic            blink_on, blink_nxt;
    logic [15:0]     evt_word, evt_word_nxt;
    logic            accept;
    logic [15:0]     disp_word;
    logic            show_blank;
    logic [3:0][6:0] seg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SHOW_SW;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack is gated by reset so a held request is never acknowledged while in reset.
    always_comb begin
        accept        = reset_n && evt_req && (state != SHOW_EVENT);
        evt_ack       = accept;
        evt_done      = (state == SHOW_EVENT) && (evt_cnt == EVENT_LAST);
        state_nxt     = state;
        dwell_nxt     = dwell_cnt;
        evt_cnt_nxt   = evt_cnt;
        blink_cnt_nxt = blink_cnt;
        blink_nxt     = blink_on;
        evt_word_nxt  = evt_word;
        if (accept) begin
            state_nxt     = SHOW_EVENT;
            evt_word_nxt  = evt_data;
            evt_cnt_nxt   = '0;
            blink_cnt_nxt = '0;
            blink_nxt     = 1'b1;
            dwell_nxt     = '0;
        end else begin
            case (state)
                SHOW_SW, SHOW_GAME: begin
                    if (!rotate_en) begin
                        state_nxt = SHOW_SW;
                        dwell_nxt = '0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        state_nxt = (state == SHOW_SW) ? SHOW_GAME : SHOW_SW;
                        dwell_nxt = '0;
                    end else begin
                        dwell_nxt = dwell_cnt + 1'b1;
                    end
                end
                SHOW_EVENT: begin
                    evt_cnt_nxt = evt_cnt + 1'b1;
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_nxt = '0;
                        blink_nxt     = ~blink_on;
                    end else begin
                        blink_cnt_nxt = blink_cnt + 1'b1;
                    end
                    if (evt_done) begin
                        state_nxt = SHOW_SW;
                        dwell_nxt = '0;
                    end
                end
                default: state_nxt = SHOW_SW;
            endcase
        end
    end

    always_comb begin
        case (state)
            SHOW_GAME:  disp_word = {score_l, score_r};
            SHOW_EVENT: disp_word = evt_word;
            default:    disp_word = sw_value;
        endcase
        show_blank = (state == SHOW_EVENT) && !blink_on;
    end

    for (genvar i = 0; i < 4; i++) begin : g_dec
        hex_to_sevenseg u_dec (
            .nibble (disp_word[4*i +: 4]),
            .seg    (seg[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_cnt <= '0;
            evt_cnt   <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            evt_word  <= '0;
            hex0      <= SEG_BLANK;
            hex1      <= SEG_BLANK;
            hex2      <= SEG_BLANK;
            hex3      <= SEG_BLANK;
            src       <= SRC_SW;
        end else begin
            dwell_cnt <= dwell_nxt;
            evt_cnt   <= evt_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_nxt;
            evt_word  <= evt_word_nxt;
            hex0      <= show_blank ? SEG_BLANK : seg[0];
            hex1      <= show_blank ? SEG_BLANK : seg[1];
            hex2      <= show_blank ? SEG_BLANK : seg[2];
            hex3      <= show_blank ? SEG_BLANK : seg[3];
            src       <= state_to_src(state);
        end
    end

endmodule

// File: tb/tb_hex_display_sched.sv
// Scoreboard bench for hex_display_sched: expected pin values are queued as each
// cycle's stimulus is driven and compared once the registered outputs update.
module tb_hex_display_sched;

    localparam int DWELL = 8;
    localparam int EVT   = 12;
    localparam int BLINK = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sw_value;
    logic [7:0]  score_l, score_r;
    logic        rotate_en, evt_req;
    logic [15:0] evt_data;
    logic        evt_ack, evt_done;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [1:0]  src;

    hex_display_sched #(
        .DWELL_CYCLES (DWELL),
        .EVENT_CYCLES (EVT),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_value  (sw_value),
        .score_l   (score_l),
        .score_r   (score_r),
        .rotate_en (rotate_en),
        .evt_req   (evt_req),
        .evt_data  (evt_data),
        .evt_ack   (evt_ack),
        .evt_done  (evt_done),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .src       (src)
    );

    always #5 clk = ~clk;

    typedef enum int {K_SW, K_GAME, K_EVT_ON, K_EVT_OFF} kind_e;
    typedef struct packed {
        logic [27:0] pins;
        logic [1:0]  src;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_evt_word;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [27:0] glyphs(input logic [15:0] w);
        return {seg_of(w[15:12]), seg_of(w[11:8]), seg_of(w[7:4]), seg_of(w[3:0])};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_blank(input string ph);
        check_val({ph, ".pins"}, 32'({hex3, hex2, hex1, hex0}), 32'h0FFF_FFFF);
        check_val({ph, ".src"}, 32'(src), 32'd0);
    endtask

    // Called just after a rising edge with this cycle's inputs already driven.
    task automatic cycle(input string ph, input kind_e k, input logic exp_ack, input logic exp_done);
        exp_t e;
        #1;
        check_val({ph, ".ack"}, 32'(evt_ack), 32'(exp_ack));
        check_val({ph, ".done"}, 32'(evt_done), 32'(exp_done));
        case (k)
            K_SW:      begin e.pins = glyphs(sw_value);           e.src = 2'd0; end
            K_GAME:    begin e.pins = glyphs({score_l, score_r}); e.src = 2'd1; end
            K_EVT_ON:  begin e.pins = glyphs(exp_evt_word);       e.src = 2'd2; end
            default:   begin e.pins = 28'h0FF_FFFF | 28'hF00_0000; e.src = 2'd2; end
        endcase
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val({ph, ".pins"}, 32'({hex3, hex2, hex1, hex0}), 32'(e.pins));
        check_val({ph, ".src"}, 32'(src), 32'(e.src));
    endtask

    function automatic kind_e blink_kind(input int k);
        return ((k / BLINK) % 2 == 0) ? K_EVT_ON : K_EVT_OFF;
    endfunction

    task automatic run_event(input string ph, input int ncyc);
        for (int k = 0; k < ncyc; k++)
            cycle(ph, blink_kind(k), 1'b0, k == EVT - 1);
    endtask

    initial begin
        sw_value     = 16'h1234;
        score_l      = 8'h00;
        score_r      = 8'h00;
        rotate_en    = 1'b0;
        evt_req      = 1'b0;
        evt_data     = 16'h0000;
        exp_evt_word = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check_blank("rst_hold");
        check_val("rst_hold.ack", 32'(evt_ack), 32'd0);
        check_val("rst_hold.done", 32'(evt_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_blank("rst_rel");
        cycle("sw_first", K_SW, 1'b0, 1'b0);
        check_val("sw_1234", 32'({hex3, hex2, hex1, hex0}), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        // Rotation: SW for 8 cycles, GAME for 8, then drop rotate_en mid-GAME.
        rotate_en = 1'b1;
        score_l   = 8'h05;
        score_r   = 8'h0A;
        for (int i = 0; i < 30; i++) begin
            if (i == 18) sw_value = 16'hABCD;
            if (i == 25) score_r = 8'h0B;
            if (i == 26) rotate_en = 1'b0;
            cycle("rot", (((i >= 8) && (i < 16)) || ((i >= 24) && (i <= 26))) ? K_GAME : K_SW,
                  1'b0, 1'b0);
        end

        // Single event with blink and done.
        evt_req  = 1'b1;
        evt_data = 16'hBEEF;
        cycle("evt_acc", K_SW, 1'b1, 1'b0);
        exp_evt_word = 16'hBEEF;
        evt_req  = 1'b0;
        evt_data = 16'h0000;
        run_event("evt", EVT);
        cycle("evt_end", K_SW, 1'b0, 1'b0);

        // Accept on the dwell terminal cycle must win over the GAME switch.
        rotate_en = 1'b1;
        for (int i = 0; i < DWELL - 1; i++)
            cycle("pri_dwell", K_SW, 1'b0, 1'b0);
        evt_req  = 1'b1;
        evt_data = 16'hC0DE;
        cycle("pri_acc", K_SW, 1'b1, 1'b0);
        exp_evt_word = 16'hC0DE;
        evt_req = 1'b0;
        run_event("pri_evt", EVT);
        cycle("pri_post0", K_SW, 1'b0, 1'b0);
        cycle("pri_post1", K_SW, 1'b0, 1'b0);
        rotate_en = 1'b0;
        cycle("pri_post2", K_SW, 1'b0, 1'b0);

        // Second request during an event waits until the cycle after done.
        evt_req  = 1'b1;
        evt_data = 16'h1111;
        cycle("busy_acc1", K_SW, 1'b1, 1'b0);
        exp_evt_word = 16'h1111;
        evt_req = 1'b0;
        for (int k = 0; k < EVT; k++) begin
            if (k == 2) begin
                evt_req  = 1'b1;
                evt_data = 16'h2222;
            end
            cycle("busy_evt1", blink_kind(k), 1'b0, k == EVT - 1);
        end
        cycle("busy_acc2", K_SW, 1'b1, 1'b0);
        exp_evt_word = 16'h2222;
        evt_req  = 1'b0;
        evt_data = 16'h0000;
        for (int k = 0; k < 4; k++)
            cycle("busy_evt2", blink_kind(k), 1'b0, 1'b0);

        // Asynchronous reset pulse in the middle of that event.
        evt_req  = 1'b1;
        evt_data = 16'h3333;
        #2;
        reset_n = 1'b0;
        #1;
        check_blank("rst_mid");
        check_val("rst_mid.done", 32'(evt_done), 32'd0);
        check_val("rst_mid.ack", 32'(evt_ack), 32'd0);
        #1;
        reset_n = 1'b1;
        cycle("rst_reacc", K_SW, 1'b1, 1'b0);
        exp_evt_word = 16'h3333;
        evt_req = 1'b0;
        run_event("rst_evt", EVT);
        cycle("rst_end", K_SW, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_sched.md
Name: hex_display_sched

Overview:
- Schedules the 4-digit HEX display between three sources: the software hex-digits PIO word, the live game score, and transient hardware events such as a "goal" flash.
- Rotates between software and score on a dwell timer. Events preempt with a req/ack handshake.
- Drives four registered active-low 7-segment outputs and sits between the SoC PIO export and the HEX pins.

Parameters:
- DWELL_CYCLES, 50_000_000, cycles each rotating source is shown (1 s at 50 MHz); must be >=2.
- EVENT_CYCLES, 100_000_000, total cycles an accepted event is shown; must be >=2.
- BLINK_CYCLES, 12_500_000, half-period of event blink; must be >=1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sw_value  in  16  software word from the hex-digits PIO out_port; nibble 3 maps to hex3.
- score_l  in  8  left-player score, shown on hex3:hex2.
- score_r  in  8  right-player score, shown on hex1:hex0.
- rotate_en  in  1  1 = alternate SW/GAME; 0 = hold SW.
- evt_req  in  1  event request, level; held by requester until evt_ack.
- evt_data  in  16  event word, sampled on the ack cycle.
- evt_ack  out  1  one-cycle pulse, event accepted.
- evt_done  out  1  one-cycle pulse, event display finished.
- hex0..hex3  out  7 each  segments {g,f,e,d,c,b,a}, active low.
- src  out  2  displayed source: 0 SW, 1 GAME, 2 EVENT.

Behaviour:
- Reset is asynchronous and active-low and applies to all flops. Reset values:
  - FSM = SHOW_SW; dwell_cnt, evt_cnt, blink_cnt = 0; blink_on = 1.
  - hex0..hex3 = 7'h7F (blank); src = 0; evt_ack = evt_done = 0; evt_word = 0.
- FSM states: SHOW_SW, SHOW_GAME, SHOW_EVENT.
- SHOW_SW / SHOW_GAME:
  - dwell_cnt increments each cycle while rotate_en = 1.
  - At dwell_cnt = DWELL_CYCLES-1: toggle SW<->GAME and clear dwell_cnt.
  - rotate_en = 0: next state SHOW_SW, dwell_cnt cleared (from either state).
- Event accept:
  - Condition: evt_req = 1 while state != SHOW_EVENT.
  - Same cycle: evt_ack = 1. Registered on that edge: evt_word <= evt_data, state <= SHOW_EVENT, evt_cnt = 0, blink_cnt = 0, blink_on = 1.
  - Accept has priority over the dwell terminal count in the same cycle.
- SHOW_EVENT:
  - evt_req is ignored (no ack); the requester keeps waiting.
  - evt_cnt increments. blink_cnt wraps at BLINK_CYCLES-1 and toggles blink_on on the wrap.
  - At evt_cnt = EVENT_CYCLES-1: evt_done = 1 that cycle; next state SHOW_SW with dwell_cnt cleared.
  - A still-asserted evt_req may then be accepted on the first SHOW_SW cycle, i.e. back-to-back events.
- Display word:
  - SW -> sw_value; GAME -> {score_l, score_r}; EVENT -> evt_word.
  - In EVENT with blink_on = 0: all digits blank (7'h7F).
- Decode:
  - Standard hex glyphs 0-F, active low (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E).
  - hex0..hex3 and src are registered from the current state: exactly 1 cycle latency from state/inputs to pins.
- Inputs are synchronous to clk; no internal synchronisers.
- A score or sw_value change is visible at the pins 1 cycle later when that source is selected.
- Reset mid-event: display blanks immediately, no evt_done is issued, and the pending request must be re-acked after reset.

Decomposition:
- Package hex_display_pkg:
  - src_e enum (SRC_SW = 2'd0, SRC_GAME = 2'd1, SRC_EVENT = 2'd2).
  - state enum.
  - SEG_BLANK = 7'h7F.
- Sub-module hex_to_sevenseg: combinational 4-bit -> 7-bit active-low decoder, instantiated 4x.
- Counters and FSM live in hex_display_sched.

Test Plan (DWELL_CYCLES = 8, EVENT_CYCLES = 12, BLINK_CYCLES = 3):
- Reset: during and 1 cycle after reset release -> hex0..3 = 7'h7F, src = 0. Next cycle with sw_value = 16'h1234 -> hex3..hex0 = 7'h79, 7'h24, 7'h30, 7'h19.
- Rotation: rotate_en = 1, score_l = 8'h05, score_r = 8'h0A -> src flips 0 -> 1 after 8 cycles (hex3..hex0 = 0,5,0,A), back to 0 after 8 more. Dropping rotate_en mid-GAME -> src = 0 within 2 cycles.
- Event: evt_req = 1, evt_data = 16'hBEEF -> evt_ack pulses once. src = 2, digits b,E,E,F with a blink pattern of 3 on / 3 off. evt_done at the 12th event cycle, then src = 0.
- Priority: evt_req asserted on the dwell terminal cycle -> event accepted, no GAME cycle shown.
- Busy: second evt_req asserted during an event -> no ack until the cycle after evt_done, then acked with its own data.
- Async reset pulse mid-event (not aligned to clk) -> outputs blank immediately, no evt_done, src = 0.
